// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin front end serializing requests onto an 8x8 register memory
module mem_port_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_0,
  input  logic          req_rd_wr_0,
  input  logic [AW-1:0] req_addr_0,
  input  logic [DW-1:0] req_wdata_0,
  output logic          req_ready_0,
  output logic          rsp_valid_0,
  output logic [DW-1:0] rsp_rdata_0,
  input  logic          req_valid_1,
  input  logic          req_rd_wr_1,
  input  logic [AW-1:0] req_addr_1,
  input  logic [DW-1:0] req_wdata_1,
  output logic          req_ready_1,
  output logic          rsp_valid_1,
  output logic [DW-1:0] rsp_rdata_1,
  output logic          mem_enable,
  output logic          mem_rd_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  state_t state, state_nx;
  logic last_grant, accept;
  always_comb begin
    req_ready_0 = ~rst & (state == IDLE) & req_valid_0 & (~req_valid_1 | last_grant);
    req_ready_1 = ~rst & (state == IDLE) & req_valid_1 & (~req_valid_0 | ~last_grant);
    accept = req_ready_0 | req_ready_1;
    state_nx = state == IDLE ? (accept ? ACCESS : IDLE) : state == ACCESS ? CAPTURE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant  <= 1'b1;
      mem_enable  <= 1'b0;
      mem_rd_wr   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_rdata_1 <= '0;
    end else begin
      mem_enable  <= accept;
      rsp_valid_0 <= (state == CAPTURE) & ~last_grant;
      rsp_valid_1 <= (state == CAPTURE) & last_grant;
      if ((state == CAPTURE) & mem_rd_wr & ~last_grant) rsp_rdata_0 <= mem_rd_data;
      if ((state == CAPTURE) & mem_rd_wr & last_grant) rsp_rdata_1 <= mem_rd_data;
      if (accept) begin
        last_grant  <= req_ready_1;
        mem_rd_wr   <= req_ready_1 ? req_rd_wr_1 : req_rd_wr_0;
        mem_addr    <= req_ready_1 ? req_addr_1 : req_addr_0;
        mem_wr_data <= req_ready_1 ? req_wdata_1 : req_wdata_0;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed check of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  typedef struct packed {logic rd; logic [2:0] a; logic [7:0] d;} req_t;
  logic clk = 0, rst = 0;
  logic req_valid_0 = 0, req_valid_1 = 0;
  req_t c0 = '0, c1 = '0;
  logic req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic mem_enable, mem_rd_wr;
  logic [2:0] mem_addr;
  logic [7:0] mem_wr_data, mem_rd_data;
  logic [7:0] mem [8];
  int nvec = 0, nerr = 0;
  int cnt;
  logic last, cur_p, cur_rd, m_en, m_rw;
  logic [7:0] cur_d, m_wd;
  logic [2:0] m_a;
  logic [1:0] e_rv;
  logic [7:0] e_rd [2];
  logic [7:0] ref_mem [8];
  req_t q0[$], q1[$];
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(3), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_rd_wr_0(c0.rd), .req_addr_0(c0.a), .req_wdata_0(c0.d),
    .req_ready_0(req_ready_0), .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_rd_wr_1(c1.rd), .req_addr_1(c1.a), .req_wdata_1(c1.d),
    .req_ready_1(req_ready_1), .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'hFF;
      mem_rd_data <= 8'h00;
    end else if (mem_enable) begin
      if (mem_rd_wr) mem_rd_data <= mem[mem_addr];
      else mem[mem_addr] <= mem_wr_data;
    end
  function automatic req_t mk(input logic rd, input logic [2:0] a, input logic [7:0] d);
    mk = '{rd: rd, a: a, d: d};
  endfunction
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    cnt = 0; last = 1; e_rv = 0; e_rd[0] = 0; e_rd[1] = 0;
    m_en = 0; m_rw = 0; m_a = 0; m_wd = 0; cur_p = 0; cur_rd = 0; cur_d = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'hFF;
    q0.delete(); q1.delete();
    req_valid_0 = 0; req_valid_1 = 0;
  endtask
  task automatic tick();
    logic x0, x1;
    req_t r;
    @(negedge clk);
    x0 = !rst && cnt == 0 && req_valid_0 && (!req_valid_1 || last);
    x1 = !rst && cnt == 0 && req_valid_1 && (!req_valid_0 || !last);
    chk("ready0", req_ready_0, x0);
    chk("ready1", req_ready_1, x1);
    chk("one_ready", req_ready_0 & req_ready_1, 0);
    chk("rsp_valid0", rsp_valid_0, e_rv[0]);
    chk("rsp_valid1", rsp_valid_1, e_rv[1]);
    chk("rsp_rdata0", rsp_rdata_0, e_rd[0]);
    chk("rsp_rdata1", rsp_rdata_1, e_rd[1]);
    chk("mem_enable", mem_enable, m_en);
    chk("mem_rd_wr", mem_rd_wr, m_rw);
    chk("mem_addr", mem_addr, m_a);
    chk("mem_wr_data", mem_wr_data, m_wd);
    @(posedge clk);
    if (!rst) begin
      e_rv = 0;
      if (cnt == 1) begin
        e_rv[cur_p] = 1;
        if (cur_rd) e_rd[cur_p] = cur_d;
      end
      m_en = x0 | x1;
      if (cnt > 0) cnt--;
      if (x0 | x1) begin
        r = x1 ? c1 : c0;
        cnt = 2; cur_p = x1; last = x1; cur_rd = r.rd;
        if (r.rd) cur_d = ref_mem[r.a];
        else ref_mem[r.a] = r.d;
        m_rw = r.rd; m_a = r.a; m_wd = r.d;
      end
    end
    #1;
    if (x0) req_valid_0 = 0;
    if (x1) req_valid_1 = 0;
    if (!req_valid_0 && q0.size() > 0) begin c0 = q0.pop_front(); req_valid_0 = 1; end
    if (!req_valid_1 && q1.size() > 0) begin c1 = q1.pop_front(); req_valid_1 = 1; end
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req_valid_0 || req_valid_1 || cnt != 0 || e_rv != 0) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_timeout", 8'(n >= lim), 0);
  endtask
  initial begin
    int n;
    rst = 1;
    model_reset();
    tick();
    tick();
    rst = 0;
    q0.push_back(mk(1, 5, 0));
    drain(20);
    q0.push_back(mk(0, 3, 8'hA5));
    q0.push_back(mk(1, 3, 0));
    drain(20);
    q0.push_back(mk(0, 1, 8'h11));
    q0.push_back(mk(0, 1, 8'h22));
    q1.push_back(mk(1, 1, 0));
    q1.push_back(mk(1, 1, 0));
    drain(40);
    for (int i = 0; i < 4; i++) q1.push_back(mk(0, 3'(i), 8'(8'h10 + i)));
    for (int i = 0; i < 4; i++) q1.push_back(mk(1, 3'(i), 0));
    drain(60);
    q0.push_back(mk(1, 3, 0));
    n = 0;
    while (cnt != 2 && n < 20) begin tick(); n++; end
    chk("rst_accept_timeout", 8'(n >= 20), 0);
    tick();
    rst = 1;
    model_reset();
    req_valid_0 = 1;
    c0 = mk(1, 4, 0);
    tick();
    tick();
    rst = 0;
    req_valid_0 = 0;
    q0.push_back(mk(1, 3, 0));
    drain(20);
    q1.push_back(mk(1, 2, 0));
    drain(20);
    q0.push_back(mk(1, 6, 0));
    q1.push_back(mk(0, 6, 8'h66));
    drain(20);
    q0.push_back(mk(1, 6, 0));
    q1.push_back(mk(1, 7, 0));
    drain(20);
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
      tick();
    end
    drain(100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin controller in front of the 8x8 register memory (enable / rd_wr / addr / wr_data in, rd_data out, read data registered one clock after an enabled read).
- Accepts read/write requests on two independent valid/ready ports and serializes them onto the single memory interface.
- Sequences memory timing and returns a one-cycle response per request: read data for reads, acknowledge for writes.

Parameters:
- AW, 3, address width; matches memory depth 8.
- DW, 8, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high; shared with the memory
- req_valid_0  in  1  port 0 request valid
- req_rd_wr_0  in  1  port 0 op: 1 = read, 0 = write (memory encoding)
- req_addr_0  in  AW  port 0 address
- req_wdata_0  in  DW  port 0 write data
- req_ready_0  out  1  port 0 request accepted this cycle
- rsp_valid_0  out  1  port 0 response pulse
- rsp_rdata_0  out  DW  port 0 read data
- req_valid_1, req_rd_wr_1, req_addr_1, req_wdata_1, req_ready_1, rsp_valid_1, rsp_rdata_1: same as port 0, for port 1
- mem_enable  out  1  to memory enable
- mem_rd_wr  out  1  to memory rd_wr
- mem_addr  out  AW  to memory addr
- mem_wr_data  out  DW  to memory wr_data
- mem_rd_data  in  DW  from memory rd_data

Behaviour:
- FSM states:
  - IDLE: ready to accept a request.
  - ACCESS: memory strobe cycle.
  - CAPTURE: read-data capture cycle.
- Transitions:
  - IDLE -> ACCESS on accept.
  - ACCESS -> CAPTURE unconditionally.
  - CAPTURE -> IDLE unconditionally.
- Arbitration and handshake:
  - req_ready_n is combinational. It is high only in IDLE with req_valid_n high and port n winning arbitration.
  - At most one ready is high per cycle.
  - A request is accepted at the edge where valid and ready are both high (edge E0).
  - Requesters hold valid and fields stable until accepted; the controller does not sample them otherwise.
- Round-robin:
  - Register last_grant resets to 1, so port 0 wins the first contention.
  - If both ports are valid in IDLE, the port != last_grant wins. If only one is valid, it wins.
  - last_grant updates on every accept.
- At E0 the granted port's rd_wr, addr and wdata and the port id are latched into registers.
- Memory drive:
  - mem_* outputs are registered.
  - mem_enable = 1 only during ACCESS (E0..E1); it is 0 in all other states.
  - mem_rd_wr, mem_addr and mem_wr_data hold the latched values from E0 until the next accept. They are 0 after reset.
- Memory operation:
  - Write: memory writes at E1.
  - Read: memory updates rd_data at E1. The controller samples mem_rd_data at E2 (end of CAPTURE) into rsp_rdata of the granted port.
- Response:
  - rsp_valid_n is registered and high for exactly one cycle, E2..E3, for the granted port only. This holds for both reads and writes.
  - rsp_rdata_n changes only at E2 of a read on port n; it holds otherwise, including across writes and the other port's reads.
- Latency: accept to rsp_valid = 2 clocks. Maximum throughput is one request per 3 clocks.
  - IDLE is re-entered at E2, so a new accept may coincide with the previous rsp_valid cycle.
- A port may present a new request while its own rsp_valid is high.
- Reset values: state IDLE, last_grant = 1, and all outputs 0: ready, rsp_valid, rsp_rdata, mem_enable, mem_rd_wr, mem_addr, mem_wr_data.
- Reset mid-operation (in ACCESS or CAPTURE):
  - Immediately abort to IDLE with all outputs 0.
  - No rsp_valid is produced for the aborted request; the requester must reissue.
  - Memory contents return to 0xFF via the shared rst.
- Boundaries:
  - Address wrap is not applicable; the full 0..7 range is legal.
  - Simultaneous valid on both ports with the same address is serialized in grant order, so a write followed by a read returns the new data.

Test Plan:
- After reset, port 0 reads addr 5 -> req_ready_0 high for 1 cycle; rsp_valid_0 pulses 2 clocks after accept; rsp_rdata_0 = 0xFF; mem_enable high exactly 1 cycle.
- Port 0 writes 0xA5 to addr 3, then reads addr 3 -> write rsp_valid_0 pulse with rsp_rdata_0 unchanged (0xFF); read returns 0xA5.
- Both ports valid continuously; port 0 writes addr 1 = 0x11, port 1 reads addr 1 -> grant order 0,1,0,1; port 1 read returns 0x11; no cycle has both readys high; accepts are spaced 3 clocks apart.
- Port 1 alone issues 4 back-to-back reads of addr 0..3 after writes 0x10..0x13 -> returns 0x10,0x11,0x12,0x13; each new accept lands in the same cycle as the prior rsp_valid_1.
- Assert rst during CAPTURE of a port 0 read -> no rsp_valid_0; all outputs 0 while rst high; a subsequent read of a previously written address returns 0xFF.
- Port 1 requests alone, then both ports request -> port 0 wins the contention (last_grant = 1); the next contention goes to port 1.
